// File: rtl/ddr3_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ddr3_bus_arbiter
//
// Shares the byte-wide CPU-side port of the DDR3 controller between two
// requesters: master 0 (Z80 CPU bus) and master 1 (DMA / video fetch).
// Requests are granted round-robin and the grant is held until the memory
// side accepts. Every accepted read leaves a one-bit tag (the issuing
// master) in a small FIFO, so read data returning later, in issue order,
// is steered back to whoever asked for it. The busy output feeds the status
// bit the test program polls on I/O port 0x30.
//
// Parameters
//   ADDR_W       memory address width
//   TAG_DEPTH    maximum outstanding reads (power of two, >= 2)
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   m0_* / m1_*                  master request channels:
//      address, valid, write, wdata   (inputs, held stable until ready)
//      ready                          request accepted this cycle
//      rdata, rdata_en                returned read data, 1-cycle pulse
//   mem_address/valid/write/wdata    request towards the DDR3 controller
//   mem_ready                        controller accepts the request
//   mem_rdata, mem_rdata_en          read data coming back, in issue order
//   busy                             a master owns the port or reads pending
//   err_orphan                       sticky: read data arrived with no tag
// ---------------------------------------------------------------------------
module ddr3_bus_arbiter #(
    parameter int ADDR_W    = 24,
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic              m0_write,
    input  logic [7:0]        m0_wdata,
    output logic [7:0]        m0_rdata,
    output logic              m0_rdata_en,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic              m1_write,
    input  logic [7:0]        m1_wdata,
    output logic [7:0]        m1_rdata,
    output logic              m1_rdata_en,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_write,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rdata_en,

    output logic              busy,
    output logic              err_orphan
);

    localparam int PTR_W = $clog2(TAG_DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL   = (PTR_W + 1)'(TAG_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t             state;
    logic               last_served;

    logic [TAG_DEPTH-1:0] tag_mem;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    logic               tag_empty;
    logic               tag_full;
    logic               tag_head;
    logic               accept;
    logic               push;
    logic               pop;

    // FIFO status flags and the master id waiting at the head of the queue.
    assign tag_empty = (count == '0);
    assign tag_full  = (count == CNT_FULL);
    assign tag_head  = tag_mem[rd_ptr];

    // Request mux towards the controller. Only the owning master is
    // forwarded; in IDLE everything is driven to zero so the controller sees
    // a quiet bus. A read is held back while the tag FIFO is full because
    // there would be nowhere to remember who issued it, but writes never
    // produce return data and can still go through.
    always_comb begin
        mem_address = '0;
        mem_write   = 1'b0;
        mem_wdata   = 8'd0;
        mem_valid   = 1'b0;
        case (state)
            OWN0: begin
                mem_address = m0_address;
                mem_write   = m0_write;
                mem_wdata   = m0_wdata;
                mem_valid   = m0_valid & (m0_write | ~tag_full);
            end
            OWN1: begin
                mem_address = m1_address;
                mem_write   = m1_write;
                mem_wdata   = m1_wdata;
                mem_valid   = m1_valid & (m1_write | ~tag_full);
            end
            default: begin
                mem_address = '0;
                mem_write   = 1'b0;
                mem_wdata   = 8'd0;
                mem_valid   = 1'b0;
            end
        endcase
    end

    // A transfer happens when the controller takes the forwarded request.
    // Ready goes back only to the owner; accepted reads are tagged, and any
    // returning beat with a tag available retires the head entry.
    assign accept   = mem_valid & mem_ready;
    assign m0_ready = accept & (state == OWN0);
    assign m1_ready = accept & (state == OWN1);
    assign push     = accept & ~mem_write;
    assign pop      = mem_rdata_en & ~tag_empty;

    // Return routing is purely combinational so the master sees its data in
    // the very cycle the controller presents it. The data bus of the master
    // that is not addressed stays at zero.
    always_comb begin
        m0_rdata_en = pop & ~tag_head;
        m1_rdata_en = pop &  tag_head;
        m0_rdata    = m0_rdata_en ? mem_rdata : 8'd0;
        m1_rdata    = m1_rdata_en ? mem_rdata : 8'd0;
    end

    // Ownership state machine. From IDLE a lone requester wins outright and
    // a tie goes to the master that was not served last. Once a transfer is
    // accepted the valid still visible belongs to that same transfer, so the
    // decision looks only at the other master: hand over if it is waiting,
    // otherwise drop back to IDLE. If the owner withdraws its request without
    // being accepted the grant is released as well.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_served <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid && m1_valid) begin
                        state <= last_served ? OWN0 : OWN1;
                    end else if (m0_valid) begin
                        state <= OWN0;
                    end else if (m1_valid) begin
                        state <= OWN1;
                    end
                end
                OWN0: begin
                    if (accept) begin
                        last_served <= 1'b0;
                        state       <= m1_valid ? OWN1 : IDLE;
                    end else if (!m0_valid) begin
                        state <= IDLE;
                    end
                end
                OWN1: begin
                    if (accept) begin
                        last_served <= 1'b1;
                        state       <= m0_valid ? OWN0 : IDLE;
                    end else if (!m1_valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Tag FIFO bookkeeping. The stored bit is the id of the master that
    // issued the read. A push and a pop in the same cycle move both pointers
    // and leave the occupancy alone. A push can never hit a full FIFO since
    // reads are stalled upstream while full.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= (state == OWN1);
                wr_ptr          <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Read data with no outstanding tag means the controller and the
    // arbiter disagree about what is in flight. Flag it and keep the flag
    // until the next reset so software can find it later.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_orphan <= 1'b0;
        end else if (mem_rdata_en && tag_empty) begin
            err_orphan <= 1'b1;
        end
    end

    // Busy while a master holds the port or any read is still owed.
    assign busy = (state != IDLE) | (count != '0);

endmodule

// File: tb/tb_ddr3_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr3_bus_arbiter
//
// Directed bench for ddr3_bus_arbiter. Stimulus tasks push the expected
// grant or return into a scoreboard queue before driving the bus; a
// separate monitor samples on the falling edge and pops an entry whenever
// the memory side accepts a request or presents read data.
// ---------------------------------------------------------------------------
module tb_ddr3_bus_arbiter;

    localparam int ADDR_W    = 24;
    localparam int TAG_DEPTH = 4;

    logic              clk;
    logic              reset_n;
    logic [ADDR_W-1:0] m0_address;
    logic              m0_valid;
    logic              m0_ready;
    logic              m0_write;
    logic [7:0]        m0_wdata;
    logic [7:0]        m0_rdata;
    logic              m0_rdata_en;
    logic [ADDR_W-1:0] m1_address;
    logic              m1_valid;
    logic              m1_ready;
    logic              m1_write;
    logic [7:0]        m1_wdata;
    logic [7:0]        m1_rdata;
    logic              m1_rdata_en;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_write;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_rdata_en;
    logic              busy;
    logic              err_orphan;

    ddr3_bus_arbiter #(
        .ADDR_W    (ADDR_W),
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m0_address   (m0_address),
        .m0_valid     (m0_valid),
        .m0_ready     (m0_ready),
        .m0_write     (m0_write),
        .m0_wdata     (m0_wdata),
        .m0_rdata     (m0_rdata),
        .m0_rdata_en  (m0_rdata_en),
        .m1_address   (m1_address),
        .m1_valid     (m1_valid),
        .m1_ready     (m1_ready),
        .m1_write     (m1_write),
        .m1_wdata     (m1_wdata),
        .m1_rdata     (m1_rdata),
        .m1_rdata_en  (m1_rdata_en),
        .mem_address  (mem_address),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rdata_en (mem_rdata_en),
        .busy         (busy),
        .err_orphan   (err_orphan)
    );

    typedef struct {
        logic [1:0]        ready;
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [7:0]        wdata;
    } grant_t;

    typedef struct {
        logic [1:0] en;
        logic [7:0] data;
    } ret_t;

    grant_t grant_q[$];
    ret_t   ret_q[$];
    int     grant_cyc[$];
    int     n_checks;
    int     n_fails;
    int     cycle_count;
    grant_t g_mon;
    ret_t   r_mon;

    // 100 MHz style clock and a free-running cycle counter for gap checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle_count = 0;
    always @(posedge clk) cycle_count <= cycle_count + 1;

    // One comparison: count it, and report a mismatch on a single line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // A comparison that cannot be made because the event never matched.
    task automatic failNow(input string name);
        n_checks++;
        n_fails++;
        $display("[TB] FAIL %s: event did not match expectation", name);
    endtask

    // Drive one master's request channel.
    task automatic setReq(input int m, input logic v, input logic [ADDR_W-1:0] a,
                          input logic w, input logic [7:0] d);
        if (m == 0) begin
            m0_valid = v; m0_address = a; m0_write = w; m0_wdata = d;
        end else begin
            m1_valid = v; m1_address = a; m1_write = w; m1_wdata = d;
        end
    endtask

    task automatic releaseReq(input int m);
        setReq(m, 1'b0, '0, 1'b0, 8'd0);
    endtask

    task automatic expectGrant(input int m, input logic [ADDR_W-1:0] a,
                               input logic w, input logic [7:0] d);
        grant_t g;
        g.ready = (m == 0) ? 2'b01 : 2'b10;
        g.addr  = a;
        g.write = w;
        g.wdata = d;
        grant_q.push_back(g);
    endtask

    // Present a request and hold it until ready is seen; returns just after
    // the accepting edge with valid still high so the caller can chain.
    task automatic driveReq(input int m, input logic [ADDR_W-1:0] a,
                            input logic w, input logic [7:0] d);
        logic got;
        setReq(m, 1'b1, a, w, d);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (m == 0) ? m0_ready : m1_ready;
        end
        if (!got) failNow("ready_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int m, input logic [ADDR_W-1:0] a,
                                 input logic w, input logic [7:0] d);
        expectGrant(m, a, w, d);
        driveReq(m, a, w, d);
        releaseReq(m);
    endtask

    // One returning read beat; called just after a rising edge.
    task automatic applyReturn(input logic [7:0] data, input logic [1:0] exp_en);
        ret_t r;
        r.en   = exp_en;
        r.data = data;
        ret_q.push_back(r);
        mem_rdata_en = 1'b1;
        mem_rdata    = data;
        @(posedge clk);
        #1;
        mem_rdata_en = 1'b0;
        mem_rdata    = 8'd0;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: every accepted request and every returning beat consumes one
    // scoreboard entry. Master pulses without a memory return are spurious.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_valid && mem_ready) begin
                grant_cyc.push_back(cycle_count);
                if (grant_q.size() == 0) begin
                    failNow("unexpected_grant");
                end else begin
                    g_mon = grant_q.pop_front();
                    checkOutput("grant_ready", {30'd0, m1_ready, m0_ready}, {30'd0, g_mon.ready});
                    checkOutput("grant_addr", 32'(mem_address), 32'(g_mon.addr));
                    checkOutput("grant_write", {31'd0, mem_write}, {31'd0, g_mon.write});
                    checkOutput("grant_wdata", {24'd0, mem_wdata}, {24'd0, g_mon.wdata});
                end
            end
            if (mem_rdata_en) begin
                if (ret_q.size() == 0) begin
                    failNow("unexpected_return");
                end else begin
                    r_mon = ret_q.pop_front();
                    checkOutput("ret_en", {30'd0, m1_rdata_en, m0_rdata_en}, {30'd0, r_mon.en});
                    checkOutput("ret_m0_data", {24'd0, m0_rdata},
                                {24'd0, (r_mon.en[0] ? r_mon.data : 8'd0)});
                    checkOutput("ret_m1_data", {24'd0, m1_rdata},
                                {24'd0, (r_mon.en[1] ? r_mon.data : 8'd0)});
                end
            end else if (m0_rdata_en || m1_rdata_en) begin
                checkOutput("spurious_rdata_en", {30'd0, m1_rdata_en, m0_rdata_en}, 32'd0);
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        reset_n      = 1'b0;
        mem_ready    = 1'b1;
        mem_rdata    = 8'd0;
        mem_rdata_en = 1'b0;
        releaseReq(0);
        releaseReq(1);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        checkOutput("reset_mem_valid", {31'd0, mem_valid}, 32'd0);
        checkOutput("reset_rdata_en", {30'd0, m1_rdata_en, m0_rdata_en}, 32'd0);
        checkOutput("reset_rdata", {16'd0, m1_rdata, m0_rdata}, 32'd0);
        checkOutput("reset_mem_address", 32'(mem_address), 32'd0);
        checkOutput("reset_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_err_orphan", {31'd0, err_orphan}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single m0 read: one cycle arbitration latency, then a return.
        $display("[TB] single m0 read");
        expectGrant(0, 24'h000010, 1'b0, 8'd0);
        setReq(0, 1'b1, 24'h000010, 1'b0, 8'd0);
        @(negedge clk);
        checkOutput("latency_cycle_n", {31'd0, mem_valid}, 32'd0);
        @(negedge clk);
        checkOutput("latency_cycle_n1", {31'd0, mem_valid}, 32'd1);
        @(posedge clk);
        #1;
        releaseReq(0);
        @(posedge clk);
        #1;
        applyReturn(8'hA5, 2'b01);
        @(negedge clk);
        checkOutput("busy_after_single", {31'd0, busy}, 32'd0);

        // Tie every cycle: m0, m1, m0, m1 with no gap.
        $display("[TB] round robin tie");
        @(posedge clk);
        #1;
        doReset();
        grant_cyc.delete();
        expectGrant(0, 24'h000020, 1'b0, 8'd0);
        expectGrant(1, 24'h000030, 1'b1, 8'h41);
        expectGrant(0, 24'h000021, 1'b1, 8'h42);
        expectGrant(1, 24'h000031, 1'b0, 8'd0);
        fork
            begin
                driveReq(0, 24'h000020, 1'b0, 8'd0);
                driveReq(0, 24'h000021, 1'b1, 8'h42);
                releaseReq(0);
            end
            begin
                driveReq(1, 24'h000030, 1'b1, 8'h41);
                driveReq(1, 24'h000031, 1'b0, 8'd0);
                releaseReq(1);
            end
        join
        checkOutput("tie_grant_count", 32'(grant_cyc.size()), 32'd4);
        if (grant_cyc.size() == 4)
            checkOutput("tie_no_bubble", 32'(grant_cyc[3] - grant_cyc[0]), 32'd3);
        applyReturn(8'h55, 2'b01);
        applyReturn(8'h66, 2'b10);

        // Fill the tag FIFO, then a read stalls while a write still passes.
        $display("[TB] tag fifo full");
        for (int i = 0; i < TAG_DEPTH; i++)
            applyStimulus(0, 24'h000100 + 24'(i), 1'b0, 8'd0);
        expectGrant(1, 24'h000200, 1'b1, 8'h77);
        expectGrant(0, 24'h000104, 1'b0, 8'd0);
        fork
            begin
                driveReq(1, 24'h000200, 1'b1, 8'h77);
                releaseReq(1);
            end
            begin
                driveReq(0, 24'h000104, 1'b0, 8'd0);
                releaseReq(0);
            end
        join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("full_read_stalled", {31'd0, mem_valid}, 32'd0);
        checkOutput("full_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        begin
            ret_t r;
            r.en   = 2'b01;
            r.data = 8'h3C;
            ret_q.push_back(r);
        end
        mem_rdata_en = 1'b1;
        mem_rdata    = 8'h3C;
        @(negedge clk);
        checkOutput("stall_during_return", {31'd0, mem_valid}, 32'd0);
        @(posedge clk);
        #1;
        mem_rdata_en = 1'b0;
        mem_rdata    = 8'd0;
        @(negedge clk);
        checkOutput("unblock_next_cycle", {31'd0, mem_valid}, 32'd1);
        wait fork;
        for (int i = 0; i < TAG_DEPTH; i++)
            applyReturn(8'h81 + 8'(i), 2'b01);
        @(negedge clk);
        checkOutput("busy_after_drain", {31'd0, busy}, 32'd0);

        // Mixed issue order and a push/pop in the same cycle.
        $display("[TB] mixed routing");
        @(posedge clk);
        #1;
        applyStimulus(1, 24'h000300, 1'b0, 8'd0);
        applyStimulus(0, 24'h000301, 1'b0, 8'd0);
        expectGrant(1, 24'h000302, 1'b0, 8'd0);
        fork
            begin
                driveReq(1, 24'h000302, 1'b0, 8'd0);
                releaseReq(1);
            end
        join_none
        @(posedge clk);
        #1;
        begin
            ret_t r;
            r.en   = 2'b10;
            r.data = 8'h11;
            ret_q.push_back(r);
        end
        mem_rdata_en = 1'b1;
        mem_rdata    = 8'h11;
        @(posedge clk);
        #1;
        mem_rdata_en = 1'b0;
        mem_rdata    = 8'd0;
        @(negedge clk);
        checkOutput("count_push_pop", 32'(dut.count), 32'd2);
        wait fork;
        applyReturn(8'h22, 2'b01);
        @(negedge clk);
        checkOutput("busy_one_left", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        applyReturn(8'h33, 2'b10);
        @(negedge clk);
        checkOutput("busy_after_mixed", {31'd0, busy}, 32'd0);

        // Orphan return with nothing outstanding.
        $display("[TB] orphan return");
        @(posedge clk);
        #1;
        applyReturn(8'h5A, 2'b00);
        @(negedge clk);
        checkOutput("orphan_set", {31'd0, err_orphan}, 32'd1);
        checkOutput("orphan_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("orphan_sticky", {31'd0, err_orphan}, 32'd1);
        @(posedge clk);
        #1;
        doReset();
        @(negedge clk);
        checkOutput("orphan_cleared", {31'd0, err_orphan}, 32'd0);

        // Reset while OWN1 holds the port with two reads outstanding.
        $display("[TB] reset mid operation");
        @(posedge clk);
        #1;
        applyStimulus(0, 24'h000400, 1'b0, 8'd0);
        applyStimulus(1, 24'h000401, 1'b0, 8'd0);
        mem_ready = 1'b0;
        setReq(1, 1'b1, 24'h000402, 1'b1, 8'h99);
        @(posedge clk);
        @(negedge clk);
        checkOutput("own1_held", {31'd0, mem_valid}, 32'd1);
        checkOutput("own1_count", 32'(dut.count), 32'd2);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        releaseReq(1);
        mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        checkOutput("midrst_mem_valid", {31'd0, mem_valid}, 32'd0);
        checkOutput("midrst_count", 32'(dut.count), 32'd0);

        // Everything expected must have been seen.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("grant_q_empty", 32'(grant_q.size()), 32'd0);
        checkOutput("ret_q_empty", 32'(ret_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
